// File: rtl/tri_edge_feeder_if.sv
// Signal bundle between tri_edge_feeder, the projected-triangle FIFO and the line drawer.
// The master side is the feeder; the slave side is the FIFO/line-drawer environment.
interface tri_edge_feeder_if #(
    parameter int XW = 10
);
    logic            fifo_empty;
    logic [6*XW-1:0] fifo_rdata;
    logic            fifo_r;
    logic [XW-1:0]   line_x0;
    logic [XW-1:0]   line_y0;
    logic [XW-1:0]   line_x1;
    logic [XW-1:0]   line_y1;
    logic            line_start;
    logic            line_done;

    modport master (
        input  fifo_empty, fifo_rdata, line_done,
        output fifo_r, line_x0, line_y0, line_x1, line_y1, line_start
    );

    modport slave (
        output fifo_empty, fifo_rdata, line_done,
        input  fifo_r, line_x0, line_y0, line_x1, line_y1, line_start
    );
endinterface

// File: rtl/tri_edge_feeder.sv
// Pops projected triangles from the FIFO and feeds their three edges to the line drawer.
// Optional build macro SKIP_ZERO_EDGE_EN: zero-length edges are skipped instead of drawn.
module tri_edge_feeder #(
    parameter int XW     = 10,
    parameter int RD_LAT = 1,
    parameter int CW     = 16
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   draw_start,
    input  logic                   proj_done,
    tri_edge_feeder_if.master      bus,
    output logic [CW-1:0]          tri_count,
    output logic                   draw_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_POP,
        S_LATCH,
        S_EDGE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

    state_t          state_q, state_d;
    logic [6*XW-1:0] tri_q, tri_d;
    logic [1:0]      idx_q, idx_d;
    logic [1:0]      lat_q, lat_d;
    logic            cnt_clr, cnt_inc, load_ep;
    logic [4*XW-1:0] ep_d;
    logic [XW-1:0]   vx [3];
    logic [XW-1:0]   vy [3];

`ifdef SKIP_ZERO_EDGE_EN
    logic zero_edge;
    assign zero_edge = (bus.line_x0 == bus.line_x1) && (bus.line_y0 == bus.line_y1);
`endif

    // NOTE: defaults first so every path assigns every signal and no latch is inferred.
    always_comb begin
        state_d        = state_q;
        tri_d          = tri_q;
        idx_d          = idx_q;
        lat_d          = lat_q;
        cnt_clr        = 1'b0;
        cnt_inc        = 1'b0;
        load_ep        = 1'b0;
        bus.fifo_r     = 1'b0;
        bus.line_start = 1'b0;
        draw_done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (draw_start) begin
                    state_d = S_CHECK;
                    cnt_clr = 1'b1;
                end
            end
            S_CHECK: begin
                if (!bus.fifo_empty)  state_d = S_POP;
                else if (proj_done)   state_d = S_DONE;
            end
            S_POP: begin
                bus.fifo_r = 1'b1;
                lat_d      = 2'd0;
                state_d    = S_LATCH;
            end
            S_LATCH: begin
                // Read data is valid only on the RD_LAT-th cycle after the pop strobe.
                if (lat_q == LAT_LAST) begin
                    tri_d   = bus.fifo_rdata;
                    idx_d   = 2'd0;
                    load_ep = 1'b1;
                    state_d = S_EDGE;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            S_EDGE: begin
`ifdef SKIP_ZERO_EDGE_EN
                if (zero_edge) begin
                    if (idx_q == 2'd2) begin
                        cnt_inc = 1'b1;
                        state_d = S_CHECK;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        load_ep = 1'b1;
                    end
                end else begin
                    bus.line_start = 1'b1;
                    state_d        = S_WAIT;
                end
`else
                bus.line_start = 1'b1;
                state_d        = S_WAIT;
`endif
            end
            S_WAIT: begin
                if (bus.line_done) begin
                    if (idx_q == 2'd2) begin
                        cnt_inc = 1'b1;
                        state_d = S_CHECK;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        load_ep = 1'b1;
                        state_d = S_EDGE;
                    end
                end
            end
            S_DONE: begin
                draw_done = 1'b1;
                if (!draw_start) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Endpoints for the edge about to be issued, taken from next-cycle triangle/index.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            vx[i] = tri_d[i*2*XW +: XW];
            vy[i] = tri_d[i*2*XW+XW +: XW];
        end
        case (idx_d)
            2'd0:    ep_d = {vx[0], vy[0], vx[1], vy[1]};
            2'd1:    ep_d = {vx[1], vy[1], vx[2], vy[2]};
            default: ep_d = {vx[2], vy[2], vx[0], vy[0]};
        endcase
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            tri_q       <= '0;
            idx_q       <= '0;
            lat_q       <= '0;
            tri_count   <= '0;
            bus.line_x0 <= '0;
            bus.line_y0 <= '0;
            bus.line_x1 <= '0;
            bus.line_y1 <= '0;
        end else begin
            state_q <= state_d;
            tri_q   <= tri_d;
            idx_q   <= idx_d;
            lat_q   <= lat_d;
            if (cnt_clr)      tri_count <= '0;
            else if (cnt_inc) tri_count <= tri_count + CW'(1);
            if (load_ep) {bus.line_x0, bus.line_y0, bus.line_x1, bus.line_y1} <= ep_d;
        end
    end

endmodule
